// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the regfile writeback port arbiter.
// Holds the buffered mul/div entry layout and the arbiter FSM states.
package rv32i_types;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FORCE   = 2'd2
  } wb_arb_state_e;

  function automatic wb_entry_t mk_entry(
    input logic [4:0]  rd,
    input logic [31:0] data
  );
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/wb_hold_fifo.sv
// Holding buffer for completed mul/div results awaiting a regfile slot.
// Power-of-2 depth; pointers wrap naturally. Storage is not reset.
module wb_hold_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  wb_entry_t                i_entry,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single regfile write port between writeback and mul/div.
// WB_ARB_STARVE_EN adds a starvation counter that force-grants the buffer.
module wb_port_arbiter
  import rv32i_types::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_wb_valid,
  input  logic [4:0]             pipe_rd,
  input  logic [31:0]            pipe_data,
  input  logic                   md_valid,
  input  logic [4:0]             md_rd,
  input  logic [31:0]            md_data,
  output logic                   md_ready,
  output logic                   rf_we,
  output logic [4:0]             rf_rd,
  output logic [31:0]            rf_wdata,
  output logic                   pipe_stall,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t     w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  logic          w_drain;
  logic          w_force;
  logic          w_pipe_gnt;
  logic          w_fifo_gnt;
  logic          w_gnt;
  logic [4:0]    w_gnt_rd;
  logic [31:0]   w_gnt_data;

  wb_arb_state_e r_state;
  logic          r_rf_we;
  logic [4:0]    r_rf_rd;
  logic [31:0]   r_rf_wdata;

  wb_hold_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_entry (mk_entry(md_rd, md_data)),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Ready comes from registered occupancy only; a drain never bypasses it.
  assign md_ready   = !w_full;
  assign w_push     = md_valid && !w_full;
  assign w_pipe_gnt = pipe_wb_valid && !w_force;
  assign w_fifo_gnt = !w_pipe_gnt && !w_empty;
  assign w_pop      = w_fifo_gnt;
  assign w_gnt      = w_pipe_gnt || w_fifo_gnt;
  assign w_drain    = w_pop && !w_push && (w_count == CW'(1));

  always_comb begin
    w_gnt_rd   = '0;
    w_gnt_data = '0;
    unique case (1'b1)
      w_pipe_gnt: begin
        w_gnt_rd   = pipe_rd;
        w_gnt_data = pipe_data;
      end
      w_fifo_gnt: begin
        w_gnt_rd   = w_head.rd;
        w_gnt_data = w_head.data;
      end
      default: begin
        w_gnt_rd   = '0;
        w_gnt_data = '0;
      end
    endcase
  end

`ifdef WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_inc;

  assign w_force      = (r_state == ST_FORCE);
  assign w_starve_inc = r_starve + SW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_starve <= '0;
          if (w_push) begin
            r_state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (w_fifo_gnt) begin
            r_starve <= '0;
            if (w_drain) begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_starve <= w_starve_inc;
            if (w_starve_inc == LIM) begin
              r_state <= ST_FORCE;
            end
          end
        end
        ST_FORCE: begin
          r_starve <= '0;
          r_state  <= w_drain ? ST_IDLE : ST_PENDING;
        end
        default: begin
          r_starve <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end
`else
  assign w_force = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (w_drain) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`endif

  assign pipe_stall = w_force;
  assign buf_count  = w_count;

  // x0 grants still use the slot but never write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_gnt && (w_gnt_rd != 5'd0);
      if (w_gnt) begin
        r_rf_rd    <= w_gnt_rd;
        r_rf_wdata <= w_gnt_data;
      end
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_rd    = r_rf_rd;
  assign rf_wdata = r_rf_wdata;

endmodule
